// File: rtl/vote_deserializer.sv
// Purpose: collects voted bits from the majority stage into WIDTH-bit words, LSB first.
// Latency: word_valid rises 1 cycle after the edge that samples the last bit of a frame.
// Backpressure: a completed word is held until word_ready; bits arriving meanwhile are dropped and set overrun.
//
// Ports:
//   clk, rst             single clock, synchronous active-high reset
//   d, d_valid           voted bit and its qualifier
//   start                one-cycle pulse that begins (or restarts) a frame
//   clr_ovr              clears the sticky overrun flag (a same-cycle set wins)
//   word, word_valid     assembled word and its valid flag
//   word_ready           downstream accept
//   busy                 high whenever the collector is not idle
//   overrun              sticky: a bit arrived while a completed word was unaccepted
module vote_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             d_valid,
    input  logic             start,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_ins;
    logic             last_bit;
    logic             handshake;
    logic             ovr_set;

    // Shift register with the incoming bit written at position bit_cnt.
    always_comb begin
        sreg_ins = sreg;
        for (int i = 0; i < WIDTH; i++) begin
            if (bit_cnt == CW'(i)) begin
                sreg_ins[i] = d;
            end
        end
    end

    assign last_bit  = (bit_cnt == CW'(WIDTH - 1));
    assign handshake = word_valid & word_ready;
    // Only HOLD has a completed word outstanding; any bit there is lost.
    assign ovr_set   = (state == S_HOLD) & d_valid;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A restart takes precedence over a final bit in the same cycle.
                if (!start && d_valid && last_bit) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (handshake) begin
                    state_nxt = start ? S_SHIFT : S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            bit_cnt    <= '0;
            sreg       <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);

            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        bit_cnt <= '0;
                        sreg    <= '0;
                    end
                end
                S_SHIFT: begin
                    if (start) begin
                        bit_cnt <= '0;
                        sreg    <= '0;
                    end else if (d_valid) begin
                        if (last_bit) begin
                            word       <= sreg_ins;
                            word_valid <= 1'b1;
                            bit_cnt    <= '0;
                            sreg       <= '0;
                        end else begin
                            sreg    <= sreg_ins;
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (handshake) begin
                        word_valid <= 1'b0;
                        bit_cnt    <= '0;
                        sreg       <= '0;
                    end
                end
                default: begin
                    word_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/vote_deserializer.md
VOTE_DESERIALIZER -- requirements
Module: vote_deserializer

Interface
REQ-001 Parameter WIDTH, default 8, number of voted bits per output word; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 d  input  1  voted bit from the upstream 3-input majority stage.
REQ-005 d_valid  input  1  qualifies d; one bit consumed per cycle with d_valid=1.
REQ-006 start  input  1  frame start; one-cycle pulse begins collection of a new word.
REQ-007 clr_ovr  input  1  clears the sticky overrun flag.
REQ-008 word  output  WIDTH  assembled word, LSB = first bit received.
REQ-009 word_valid  output  1  word holds a complete frame.
REQ-010 word_ready  input  1  downstream accepts word.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 overrun  output  1  sticky; a voted bit arrived while a completed word was unaccepted.

Function
REQ-013 FSM states: IDLE, SHIFT, HOLD; encoding is implementer's choice.
REQ-014 IDLE: d_valid ignored; start=1 -> SHIFT, bit counter cleared to 0, shift register cleared to 0.
REQ-015 SHIFT: each cycle with d_valid=1 writes d into bit position bit_cnt of the shift register and increments bit_cnt.
REQ-016 SHIFT: the cycle that samples bit WIDTH-1 loads the full word into the word register; word_valid=1 on the following cycle; state -> HOLD.
REQ-017 Latency: word_valid rises exactly 1 cycle after the edge that samples the last bit.
REQ-018 bit_cnt width = ceil(log2(WIDTH))+1; no wrap-around; never exceeds WIDTH-1 while in SHIFT.
REQ-019 start=1 in SHIFT: partial frame discarded, bit_cnt and shift register cleared, state stays SHIFT; d_valid in that same cycle is ignored.
REQ-020 HOLD: word and word_valid held stable until word_valid & word_ready.
REQ-021 HOLD handshake: word_valid=0 next cycle; state -> IDLE, or -> SHIFT (counter cleared) if start=1 in the handshake cycle.
REQ-022 HOLD without handshake: start ignored; d_valid=1 sets overrun, bit dropped.
REQ-023 HOLD with handshake and d_valid=1 in the same cycle: bit dropped, overrun set.
REQ-024 clr_ovr=1 clears overrun next cycle; if a set condition occurs in the same cycle, set wins.
REQ-025 word_ready ignored when word_valid=0.
REQ-026 busy is a registered function of state: 1 in SHIFT and HOLD, 0 in IDLE.
REQ-027 word register changes only on the final-bit load of REQ-016; otherwise retains last value.

Reset
REQ-028 rst=1 on a rising edge forces: state IDLE, bit_cnt 0, shift register 0, word 0, word_valid 0, busy 0, overrun 0.
REQ-029 rst has priority over all other inputs, including mid-frame and in HOLD; an in-progress or pending word is discarded.
REQ-030 All outputs are registered; values defined from the first edge with rst=1.

Verification
REQ-031 WIDTH=8; start, then d = 1,0,1,1,0,0,1,0 on 8 consecutive d_valid cycles, word_ready=1 -> word=8'h4D, word_valid high 1 cycle exactly 1 cycle after the 8th bit, state IDLE after.
REQ-032 Complete a word 8'hFF with word_ready=0 for 5 cycles, d_valid=1 on cycle 3 -> word stays 8'hFF, word_valid stays 1, overrun=1; clr_ovr pulse -> overrun=0.
REQ-033 start, 3 bits (1,1,1), start again, 8 bits all 0 -> word=8'h00; no trace of the partial frame.
REQ-034 Handshake cycle with start=1, followed by 8 bits 0,1,0,1,0,1,0,1 -> second word=8'hAA, busy never drops between frames.
REQ-035 rst=1 after 5 bits of a frame -> next cycle busy=0, word=0, word_valid=0; subsequent d_valid without start produces no word.
REQ-036 clr_ovr and overrun-set condition in the same cycle -> overrun remains 1.
